// File: rtl/sip_in_fifo_if.sv
// Handshake/data bundle between the capture-side writer, the fabric reader and sip_in_fifo.
// Optional OVERFLOW/UNDERFLOW appear only when SIP_IN_FIFO_ERR_FLAGS_EN is defined.
interface sip_in_fifo_if;
  logic       WREN;
  logic       RDEN;
  logic [3:0] D0, D1, D2, D3, D4, D7, D8, D9;
  logic [7:0] D5, D6;
  logic [7:0] Q0, Q1, Q2, Q3, Q4, Q5, Q6, Q7, Q8, Q9;
  logic       EMPTY;
  logic       FULL;
  logic       ALMOSTEMPTY;
  logic       ALMOSTFULL;
`ifdef SIP_IN_FIFO_ERR_FLAGS_EN
  logic       OVERFLOW;
  logic       UNDERFLOW;

  modport master (
    output WREN, RDEN, D0, D1, D2, D3, D4, D5, D6, D7, D8, D9,
    input  Q0, Q1, Q2, Q3, Q4, Q5, Q6, Q7, Q8, Q9,
    input  EMPTY, FULL, ALMOSTEMPTY, ALMOSTFULL, OVERFLOW, UNDERFLOW
  );
  modport slave (
    input  WREN, RDEN, D0, D1, D2, D3, D4, D5, D6, D7, D8, D9,
    output Q0, Q1, Q2, Q3, Q4, Q5, Q6, Q7, Q8, Q9,
    output EMPTY, FULL, ALMOSTEMPTY, ALMOSTFULL, OVERFLOW, UNDERFLOW
  );
`else
  modport master (
    output WREN, RDEN, D0, D1, D2, D3, D4, D5, D6, D7, D8, D9,
    input  Q0, Q1, Q2, Q3, Q4, Q5, Q6, Q7, Q8, Q9,
    input  EMPTY, FULL, ALMOSTEMPTY, ALMOSTFULL
  );
  modport slave (
    input  WREN, RDEN, D0, D1, D2, D3, D4, D5, D6, D7, D8, D9,
    output Q0, Q1, Q2, Q3, Q4, Q5, Q6, Q7, Q8, Q9,
    output EMPTY, FULL, ALMOSTEMPTY, ALMOSTFULL
  );
`endif
endinterface

// File: rtl/sip_in_fifo.sv
// Single-clock 8-entry PHY byte-lane input FIFO; 4x8 mode packs two nibble writes per entry.
// Optional sticky OVERFLOW/UNDERFLOW outputs under macro SIP_IN_FIFO_ERR_FLAGS_EN.
// Handshake: a write is taken on an edge with WREN && !FULL, a read with RDEN && !EMPTY;
// Q loads on the read edge and holds otherwise; blocked requests change nothing.
module sip_in_fifo #(
  parameter int ALMOST_EMPTY_VALUE = 1,
  parameter int ALMOST_FULL_VALUE  = 1,
  parameter int ARRAY_MODE         = 1,
  parameter int DEPTH              = 8
) (
  input  logic                       WRCLK,
  input  logic                       RESET,
  sip_in_fifo_if.slave               bus,
  output logic                       dbg_pack_phase,
  output logic [$clog2(DEPTH+1)-1:0] dbg_count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] AE_TH   = CW'(ALMOST_EMPTY_VALUE);
  localparam logic [CW-1:0] AF_TH   = CW'(DEPTH - ALMOST_FULL_VALUE);
  localparam logic [CW-1:0] FULL_TH = CW'(DEPTH);
  localparam logic [0:0] PH_LOW  = 1'b0;
  localparam logic [0:0] PH_HIGH = 1'b1;

  if (ALMOST_EMPTY_VALUE < 1 || ALMOST_EMPTY_VALUE > 2) begin : g_bad_ae
    $error("sip_in_fifo: ALMOST_EMPTY_VALUE must be 1..2");
  end
  if (ALMOST_FULL_VALUE < 1 || ALMOST_FULL_VALUE > 2) begin : g_bad_af
    $error("sip_in_fifo: ALMOST_FULL_VALUE must be 1..2");
  end
  if (ARRAY_MODE != 0 && ARRAY_MODE != 1) begin : g_bad_mode
    $error("sip_in_fifo: ARRAY_MODE must be 0 or 1");
  end
  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("sip_in_fifo: DEPTH must be a power of two >= 2");
  end

  logic [7:0][3:0] nib;
  logic [7:0][3:0] staged;
  logic [9:0][7:0] commit_data;
  logic [9:0][7:0] q_r;
  logic [9:0][7:0] mem [DEPTH];
  logic [AW-1:0]   wr_ptr, rd_ptr;
  logic [CW-1:0]   count, count_next;
  logic [0:0]      phase;
  logic            empty_r, full_r, ae_r, af_r;
  logic            wr_fire, rd_fire, commit;

  // Nibble lanes in order D0..D4, D7..D9; D5/D6 bypass the staging path.
  assign nib = {bus.D9, bus.D8, bus.D7, bus.D4, bus.D3, bus.D2, bus.D1, bus.D0};

  assign wr_fire = bus.WREN && !full_r;
  assign rd_fire = bus.RDEN && !empty_r;
  assign commit  = wr_fire && ((ARRAY_MODE == 0) || (phase == PH_HIGH));

  always_comb begin
    commit_data = '0;
    for (int k = 0; k < 8; k++) begin
      if (ARRAY_MODE != 0) commit_data[(k < 5) ? k : k + 2] = {nib[k], staged[k]};
      else                 commit_data[(k < 5) ? k : k + 2] = {4'h0, nib[k]};
    end
    commit_data[5] = bus.D5;
    commit_data[6] = bus.D6;
  end

  always_comb begin
    count_next = count;
    if (commit && !rd_fire)      count_next = count + 1'b1;
    else if (!commit && rd_fire) count_next = count - 1'b1;
  end

  always_ff @(posedge WRCLK) begin
    if (commit) mem[wr_ptr] <= commit_data;
  end

  always_ff @(posedge WRCLK) begin
    if (RESET) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      phase   <= PH_LOW;
      staged  <= '0;
      q_r     <= '0;
      empty_r <= 1'b1;
      ae_r    <= 1'b1;
      full_r  <= 1'b0;
      af_r    <= 1'b0;
    end else begin
      if (wr_fire && ARRAY_MODE != 0) phase <= (phase == PH_LOW) ? PH_HIGH : PH_LOW;
      if (wr_fire && phase == PH_LOW) staged <= nib;
      if (commit) wr_ptr <= wr_ptr + 1'b1;
      if (rd_fire) begin
        rd_ptr <= rd_ptr + 1'b1;
        q_r    <= mem[rd_ptr];
      end
      // Flags come straight from the post-edge count so they never lag.
      count   <= count_next;
      empty_r <= (count_next == '0);
      ae_r    <= (count_next <= AE_TH);
      full_r  <= (count_next == FULL_TH);
      af_r    <= (count_next >= AF_TH);
    end
  end

`ifdef SIP_IN_FIFO_ERR_FLAGS_EN
  logic ovf_r, unf_r;
  always_ff @(posedge WRCLK) begin
    if (RESET) begin
      ovf_r <= 1'b0;
      unf_r <= 1'b0;
    end else begin
      if (bus.WREN && full_r)  ovf_r <= 1'b1;
      if (bus.RDEN && empty_r) unf_r <= 1'b1;
    end
  end
  assign bus.OVERFLOW  = ovf_r;
  assign bus.UNDERFLOW = unf_r;
`endif

  assign bus.Q0 = q_r[0];
  assign bus.Q1 = q_r[1];
  assign bus.Q2 = q_r[2];
  assign bus.Q3 = q_r[3];
  assign bus.Q4 = q_r[4];
  assign bus.Q5 = q_r[5];
  assign bus.Q6 = q_r[6];
  assign bus.Q7 = q_r[7];
  assign bus.Q8 = q_r[8];
  assign bus.Q9 = q_r[9];
  assign bus.EMPTY       = empty_r;
  assign bus.FULL        = full_r;
  assign bus.ALMOSTEMPTY = ae_r;
  assign bus.ALMOSTFULL  = af_r;
  assign dbg_pack_phase  = phase[0];
  assign dbg_count       = count;
endmodule

// File: tb/tb_sip_in_fifo.sv
// Self-checking bench: a 4x8 instance and a 4x4 instance run in lockstep against a queue model.
module tb_sip_in_fifo;
  logic       WRCLK = 1'b0;
  logic       RESET = 1'b1;
  logic       dbg_phase8, dbg_phase4;
  logic [3:0] dbg_count8, dbg_count4;

  sip_in_fifo_if bus8();
  sip_in_fifo_if bus4();

  sip_in_fifo #(.ALMOST_EMPTY_VALUE(1), .ALMOST_FULL_VALUE(1), .ARRAY_MODE(1), .DEPTH(8)) u_dut8 (
    .WRCLK(WRCLK), .RESET(RESET), .bus(bus8), .dbg_pack_phase(dbg_phase8), .dbg_count(dbg_count8));
  sip_in_fifo #(.ALMOST_EMPTY_VALUE(2), .ALMOST_FULL_VALUE(1), .ARRAY_MODE(0), .DEPTH(8)) u_dut4 (
    .WRCLK(WRCLK), .RESET(RESET), .bus(bus4), .dbg_pack_phase(dbg_phase4), .dbg_count(dbg_count4));

  always #5 WRCLK = ~WRCLK;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: queue of committed entries, lanes as bytes at [8*i +: 8].
  logic [79:0] m8_q[$];
  logic [79:0] m4_q[$];
  logic [79:0] m8_out, m4_out, m8_stg;
  bit          m8_ph;
  bit          m8_ov, m8_un, m4_ov, m4_un;
  logic [7:0]  exp_q[$];

  typedef struct {
    bit         we;
    bit         re;
    logic [3:0] d0;
    logic [7:0] d5;
    logic [7:0] eq0;
    logic [7:0] eq5;
    logic [3:0] ef;
  } vec_t;
  vec_t tbl[5];

  task automatic chk(input string name, input logic [79:0] act, input logic [79:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [79:0] form_entry(input logic [79:0] lo, input logic [79:0] hi, input bit pack);
    logic [79:0] e;
    e = hi;
    for (int i = 0; i < 10; i++)
      if (i != 5 && i != 6)
        e[8*i +: 8] = pack ? {hi[8*i +: 4], lo[8*i +: 4]} : {4'h0, hi[8*i +: 4]};
    return e;
  endfunction

  function automatic logic [3:0] model_flags(input int n, input int aev, input int afv);
    return {n == 0, n <= aev, n == 8, n >= 8 - afv};
  endfunction

  function automatic logic [79:0] get_q8();
    return {bus8.Q9, bus8.Q8, bus8.Q7, bus8.Q6, bus8.Q5, bus8.Q4, bus8.Q3, bus8.Q2, bus8.Q1, bus8.Q0};
  endfunction
  function automatic logic [79:0] get_q4();
    return {bus4.Q9, bus4.Q8, bus4.Q7, bus4.Q6, bus4.Q5, bus4.Q4, bus4.Q3, bus4.Q2, bus4.Q1, bus4.Q0};
  endfunction

  task automatic drive(input bit we8, input bit re8, input logic [79:0] d8,
                       input bit we4, input bit re4, input logic [79:0] d4);
    bus8.WREN = we8; bus8.RDEN = re8;
    bus8.D0 = d8[3:0];   bus8.D1 = d8[11:8];  bus8.D2 = d8[19:16]; bus8.D3 = d8[27:24];
    bus8.D4 = d8[35:32]; bus8.D5 = d8[47:40]; bus8.D6 = d8[55:48]; bus8.D7 = d8[59:56];
    bus8.D8 = d8[67:64]; bus8.D9 = d8[75:72];
    bus4.WREN = we4; bus4.RDEN = re4;
    bus4.D0 = d4[3:0];   bus4.D1 = d4[11:8];  bus4.D2 = d4[19:16]; bus4.D3 = d4[27:24];
    bus4.D4 = d4[35:32]; bus4.D5 = d4[47:40]; bus4.D6 = d4[55:48]; bus4.D7 = d4[59:56];
    bus4.D8 = d4[67:64]; bus4.D9 = d4[75:72];
  endtask

  task automatic compare_all();
    chk("q8", get_q8(), m8_out);
    chk("flags8", 80'({bus8.EMPTY, bus8.ALMOSTEMPTY, bus8.FULL, bus8.ALMOSTFULL}),
        80'(model_flags(m8_q.size(), 1, 1)));
    chk("phase8", 80'(dbg_phase8), 80'(m8_ph));
    chk("q4", get_q4(), m4_out);
    chk("flags4", 80'({bus4.EMPTY, bus4.ALMOSTEMPTY, bus4.FULL, bus4.ALMOSTFULL}),
        80'(model_flags(m4_q.size(), 2, 1)));
    chk("count4", 80'(dbg_count4), 80'(m4_q.size()));
`ifdef SIP_IN_FIFO_ERR_FLAGS_EN
    chk("err8", 80'({bus8.OVERFLOW, bus8.UNDERFLOW}), 80'({m8_ov, m8_un}));
    chk("err4", 80'({bus4.OVERFLOW, bus4.UNDERFLOW}), 80'({m4_ov, m4_un}));
`endif
  endtask

  task automatic step(input bit we8, input bit re8, input logic [79:0] d8,
                      input bit we4, input bit re4, input logic [79:0] d4);
    bit full, empty;
    drive(we8, re8, d8, we4, re4, d4);
    @(posedge WRCLK);
    full = (m8_q.size() == 8); empty = (m8_q.size() == 0);
    if (we8 && full) m8_ov = 1;
    if (re8 && empty) m8_un = 1;
    if (re8 && !empty) m8_out = m8_q.pop_front();
    if (we8 && !full) begin
      if (!m8_ph) begin m8_stg = d8; m8_ph = 1; end
      else begin m8_q.push_back(form_entry(m8_stg, d8, 1'b1)); m8_ph = 0; end
    end
    full = (m4_q.size() == 8); empty = (m4_q.size() == 0);
    if (we4 && full) m4_ov = 1;
    if (re4 && empty) m4_un = 1;
    if (re4 && !empty) m4_out = m4_q.pop_front();
    if (we4 && !full) m4_q.push_back(form_entry('0, d4, 1'b0));
    #1;
    compare_all();
  endtask

  task automatic do_reset(input bit we, input bit re);
    drive(we, re, '1, we, re, '1);
    RESET = 1'b1;
    repeat (2) @(posedge WRCLK);
    m8_q.delete(); m4_q.delete();
    m8_out = '0; m4_out = '0; m8_stg = '0; m8_ph = 0;
    m8_ov = 0; m8_un = 0; m4_ov = 0; m4_un = 0;
    #1;
    RESET = 1'b0;
    drive(0, 0, '0, 0, 0, '0);
    compare_all();
  endtask

  function automatic logic [79:0] rand80();
    logic [79:0] d;
    d[31:0]  = $urandom();
    d[63:32] = $urandom();
    d[79:64] = 16'($urandom());
    return d;
  endfunction

  function automatic logic [79:0] d0_only(input logic [3:0] v);
    logic [79:0] d;
    d = '0;
    d[3:0] = v;
    return d;
  endfunction

  initial begin
    logic [79:0] d;
    tbl[0] = '{we: 1, re: 0, d0: 4'h3, d5: 8'h11, eq0: 8'h00, eq5: 8'h00, ef: 4'b1100};
    tbl[1] = '{we: 1, re: 0, d0: 4'hA, d5: 8'h5C, eq0: 8'h00, eq5: 8'h00, ef: 4'b0100};
    tbl[2] = '{we: 0, re: 1, d0: 4'h0, d5: 8'h00, eq0: 8'hA3, eq5: 8'h5C, ef: 4'b1100};
    tbl[3] = '{we: 0, re: 0, d0: 4'h0, d5: 8'h00, eq0: 8'hA3, eq5: 8'h5C, ef: 4'b1100};
    tbl[4] = '{we: 0, re: 1, d0: 4'h0, d5: 8'h00, eq0: 8'hA3, eq5: 8'h5C, ef: 4'b1100};

    drive(0, 0, '0, 0, 0, '0);
    do_reset(1, 1);
    chk("reset_q8", get_q8(), 80'h0);
    chk("reset_flags4", 80'({bus4.EMPTY, bus4.ALMOSTEMPTY, bus4.FULL, bus4.ALMOSTFULL}), 80'(4'b1100));

    // 4x8 nibble pack and empty-read hold
    for (int i = 0; i < 5; i++) begin
      d = '0; d[3:0] = tbl[i].d0; d[47:40] = tbl[i].d5;
      step(tbl[i].we, tbl[i].re, d, 0, 0, '0);
      chk($sformatf("tbl%0d_q0", i), 80'(bus8.Q0), 80'(tbl[i].eq0));
      chk($sformatf("tbl%0d_q5", i), 80'(bus8.Q5), 80'(tbl[i].eq5));
      chk($sformatf("tbl%0d_flags", i),
          80'({bus8.EMPTY, bus8.ALMOSTEMPTY, bus8.FULL, bus8.ALMOSTFULL}), 80'(tbl[i].ef));
    end

    // 4x4 fill, overflow drop, drain in order
    do_reset(0, 0);
    for (int i = 0; i < 8; i++) begin
      step(0, 0, '0, 1, 0, d0_only(4'(i)));
      if (i == 5) chk("fill_af_after6", 80'(bus4.ALMOSTFULL), 80'(0));
      if (i == 6) chk("fill_af_after7", 80'({bus4.ALMOSTFULL, bus4.FULL}), 80'(2'b10));
      if (i == 7) chk("fill_full_after8", 80'(bus4.FULL), 80'(1));
    end
    step(0, 0, '0, 1, 0, d0_only(4'hF));
    chk("fill_9th_dropped", 80'(dbg_count4), 80'(8));
    for (int i = 0; i < 8; i++) begin
      step(0, 0, '0, 0, 1, '0);
      chk($sformatf("drain_q0_%0d", i), 80'(bus4.Q0), 80'(i));
    end
    chk("drain_empty", 80'(bus4.EMPTY), 80'(1));

    // Wrap: two rounds of 6 push / 6 pop
    for (int r = 0; r < 2; r++) begin
      for (int i = 0; i < 6; i++) begin
        d = rand80();
        exp_q.push_back({4'h0, d[3:0]});
        step(0, 0, '0, 1, 0, d);
      end
      for (int i = 0; i < 6; i++) begin
        step(0, 0, '0, 0, 1, '0);
        chk("wrap_q0", 80'(bus4.Q0), 80'(exp_q.pop_front()));
      end
    end
    chk("wrap_empty", 80'(bus4.EMPTY), 80'(1));

    // Simultaneous read/write at count 3
    for (int i = 0; i < 3; i++) step(0, 0, '0, 1, 0, d0_only(4'(i + 4)));
    step(0, 0, '0, 1, 1, d0_only(4'h9));
    chk("simul_count", 80'(dbg_count4), 80'(3));
    chk("simul_ae", 80'(bus4.ALMOSTEMPTY), 80'(0));
    chk("simul_q0", 80'(bus4.Q0), 80'(4));

    // Reset mid-pack discards the staged nibble
    do_reset(0, 0);
    step(1, 0, d0_only(4'h7), 0, 0, '0);
    do_reset(1, 0);
    step(1, 0, d0_only(4'h1), 0, 0, '0);
    step(1, 0, d0_only(4'h2), 0, 0, '0);
    step(0, 1, '0, 0, 0, '0);
    chk("midpack_q0", 80'(bus8.Q0), 80'(8'h21));
    chk("midpack_empty", 80'(bus8.EMPTY), 80'(1));

    // Random traffic, alternating write-heavy and read-heavy phases
    for (int c = 0; c < 600; c++) begin
      int wb;
      wb = ((c / 50) % 2 == 0) ? 75 : 30;
      if ($urandom_range(0, 99) == 0) do_reset($urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1);
      else step($urandom_range(0, 99) < wb, $urandom_range(0, 99) < 100 - wb, rand80(),
                $urandom_range(0, 99) < wb, $urandom_range(0, 99) < 100 - wb, rand80());
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
